// File: rtl/sss_pattern_sched.sv
// Pattern scheduler for the six-digit sss message display.
// Steps the pattern select p through 0..P_LAST with a programmable dwell while
// run is high. It also serves a one-shot override that shows a requested
// pattern for OVR_HOLD cycles and then resumes the auto sequence where it
// left off.
module sss_pattern_sched #(
  parameter int unsigned DWELL    = 50,
  parameter int unsigned OVR_HOLD = 100,
  parameter int unsigned P_LAST   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  input  logic       ovr_valid,
  input  logic [2:0] ovr_p,
  output logic       ovr_ready,
  output logic [2:0] p,
  output logic       load,
  output logic [1:0] mode,
  output logic       seq_wrap
);

  // One counter is shared by the auto dwell and the override hold, so it is
  // sized for the longer of the two.
  localparam int unsigned CntMax = ((DWELL > OVR_HOLD) ? DWELL : OVR_HOLD) - 1;
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;

  localparam logic [CntW-1:0] DwellEnd = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] HoldEnd  = CntW'(OVR_HOLD - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [2:0]      PLast    = 3'(P_LAST);

  // Encodings double as the mode output.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAuto = 2'b01,
    StOvr  = 2'b10
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      p_q;
  logic [2:0]      saved_q;
  logic            load_q;
  logic            wrap_q;

  logic [2:0]      p_step;
  logic            step_wraps;
  logic [2:0]      ovr_p_clamped;
  logic            ovr_take;

  // Handshake is open whenever no override is being shown.
  assign ovr_ready = (state_q != StOvr) && !reset;
  assign ovr_take  = ovr_valid && ovr_ready;

  assign p        = p_q;
  assign load     = load_q;
  assign seq_wrap = wrap_q;
  assign mode     = state_q;

  // Clamp out-of-range override requests to the last pattern.
  always_comb begin
    ovr_p_clamped = ovr_p;
    if (ovr_p > PLast) begin
      ovr_p_clamped = PLast;
    end
  end

  // Next pattern in the auto sequence for the current direction, with wrap flag.
  always_comb begin
    p_step     = p_q;
    step_wraps = 1'b0;
    if (dir) begin
      if (p_q == 3'd0) begin
        p_step     = PLast;
        step_wraps = 1'b1;
      end else begin
        p_step = p_q - 3'd1;
      end
    end else begin
      if (p_q >= PLast) begin
        p_step     = 3'd0;
        step_wraps = 1'b1;
      end else begin
        p_step = p_q + 3'd1;
      end
    end
  end

  // Scheduler FSM with registered pattern, load and wrap outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= 3'd0;
      saved_q <= 3'd0;
      load_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      wrap_q <= 1'b0;
      if (ovr_take) begin
        // Override beats both a pending advance and a run rising edge; the
        // pre-advance pattern is what gets restored.
        saved_q <= p_q;
        p_q     <= ovr_p_clamped;
        load_q  <= 1'b1;
        cnt_q   <= '0;
        state_q <= StOvr;
      end else begin
        case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (run) begin
              // Re-announce the held pattern on entry to auto mode.
              state_q <= StAuto;
              load_q  <= 1'b1;
            end
          end
          StAuto: begin
            if (!run) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == DwellEnd) begin
              p_q    <= p_step;
              wrap_q <= step_wraps;
              load_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          StOvr: begin
            if (cnt_q == HoldEnd) begin
              // Restore and restart a full dwell from zero.
              p_q     <= saved_q;
              load_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= run ? StAuto : StIdle;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sss_pattern_sched.sv
// Directed bench for sss_pattern_sched with DWELL=4, OVR_HOLD=6, P_LAST=5.
// Expected per-cycle outputs are queued as stimulus is planned, then popped
// and compared #1 after each rising edge.
module tb_sss_pattern_sched;

  localparam int unsigned Dwell   = 4;
  localparam int unsigned OvrHold = 6;
  localparam int unsigned PLast   = 5;

  logic       clk;
  logic       reset;
  logic       run;
  logic       dir;
  logic       ovr_valid;
  logic [2:0] ovr_p;
  logic       ovr_ready;
  logic [2:0] p;
  logic       load;
  logic [1:0] mode;
  logic       seq_wrap;

  typedef struct packed {
    logic [2:0] p;
    logic       load;
    logic [1:0] mode;
    logic       wrap;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   passed;
  int   total;

  sss_pattern_sched #(
    .DWELL    (Dwell),
    .OVR_HOLD (OvrHold),
    .P_LAST   (PLast)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .dir       (dir),
    .ovr_valid (ovr_valid),
    .ovr_p     (ovr_p),
    .ovr_ready (ovr_ready),
    .p         (p),
    .load      (load),
    .mode      (mode),
    .seq_wrap  (seq_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue n identical expected cycles.
  task automatic push(input logic [2:0] ep, input logic el, input logic [1:0] em,
                      input logic ew, input logic er, input int n);
    exp_t e;
    e.p     = ep;
    e.load  = el;
    e.mode  = em;
    e.wrap  = ew;
    e.ready = er;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One auto-mode pattern: load (and optional wrap) on the first cycle, then held.
  task automatic push_auto(input logic [2:0] ep, input logic ew);
    push(ep, 1'b1, 2'b01, ew, 1'b1, 1);
    push(ep, 1'b0, 2'b01, 1'b0, 1'b1, Dwell - 1);
  endtask

  task automatic check(input string tag, input int cyc, input logic [3:0] got,
                       input logic [3:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, want);
  endtask

  int cycle_no;

  // Advance n cycles, comparing each against the head of the scoreboard.
  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() == 0) begin
        total++;
        $error("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cycle_no);
      end else begin
        e = exp_q.pop_front();
        check("p", cycle_no, {1'b0, p}, {1'b0, e.p});
        check("load", cycle_no, {3'b0, load}, {3'b0, e.load});
        check("mode", cycle_no, {2'b0, mode}, {2'b0, e.mode});
        check("seq_wrap", cycle_no, {3'b0, seq_wrap}, {3'b0, e.wrap});
        check("ovr_ready", cycle_no, {3'b0, ovr_ready}, {3'b0, e.ready});
      end
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    cycle_no  = 0;
    reset     = 1'b1;
    run       = 1'b1;
    dir       = 1'b0;
    ovr_valid = 1'b1;
    ovr_p     = 3'd3;

    // Reset dominates run and a pending override.
    push(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3);
    step(3);

    // Released with run low: idle, handshake open, p parked at 0.
    reset     = 1'b0;
    run       = 1'b0;
    ovr_valid = 1'b0;
    push(3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 20);
    step(20);

    // Auto up: 0 re-announced, then 1..5, wrap to 0, then 1.
    run = 1'b1;
    dir = 1'b0;
    push_auto(3'd0, 1'b0);
    for (int v = 1; v <= 5; v++) push_auto(3'(v), 1'b0);
    push_auto(3'd0, 1'b1);
    push_auto(3'd1, 1'b0);
    step(32);

    // Auto down: 1 -> 0 -> 5 (wrap) -> 4.
    dir = 1'b1;
    push_auto(3'd0, 1'b0);
    push_auto(3'd5, 1'b1);
    push_auto(3'd4, 1'b0);
    step(12);

    // Step down to 3 and stop at counter=1.
    push(3'd3, 1'b1, 2'b01, 1'b0, 1'b1, 1);
    push(3'd3, 1'b0, 2'b01, 1'b0, 1'b1, 1);
    step(2);

    // Override to 4; restore 3 with a full dwell, then advance up to 4.
    ovr_valid = 1'b1;
    ovr_p     = 3'd4;
    push(3'd4, 1'b1, 2'b10, 1'b0, 1'b0, 1);
    step(1);
    ovr_valid = 1'b0;
    dir       = 1'b0;
    push(3'd4, 1'b0, 2'b10, 1'b0, 1'b0, OvrHold - 1);
    push_auto(3'd3, 1'b0);
    push(3'd4, 1'b1, 2'b01, 1'b0, 1'b1, 1);
    step(10);

    // Second request held through an override stalls until the return.
    ovr_valid = 1'b1;
    ovr_p     = 3'd1;
    push(3'd1, 1'b1, 2'b10, 1'b0, 1'b0, 1);
    step(1);
    ovr_p = 3'd2;
    push(3'd1, 1'b0, 2'b10, 1'b0, 1'b0, OvrHold - 1);
    push(3'd4, 1'b1, 2'b01, 1'b0, 1'b1, 1);
    step(OvrHold);
    push(3'd2, 1'b1, 2'b10, 1'b0, 1'b0, 1);
    step(1);
    ovr_valid = 1'b0;
    push(3'd2, 1'b0, 2'b10, 1'b0, 1'b0, OvrHold - 1);
    push(3'd4, 1'b1, 2'b01, 1'b0, 1'b1, 1);
    step(OvrHold);

    // Step down to 2 and stop on the advance cycle.
    dir = 1'b1;
    push(3'd4, 1'b0, 2'b01, 1'b0, 1'b1, Dwell - 1);
    push_auto(3'd3, 1'b0);
    push_auto(3'd2, 1'b0);
    step(11);

    // Collision: clamped override wins over the advance, saved_p stays 2.
    ovr_valid = 1'b1;
    ovr_p     = 3'd7;
    push(3'd5, 1'b1, 2'b10, 1'b0, 1'b0, 1);
    step(1);
    ovr_valid = 1'b0;
    run       = 1'b0;
    push(3'd5, 1'b0, 2'b10, 1'b0, 1'b0, OvrHold - 1);
    push(3'd2, 1'b1, 2'b00, 1'b0, 1'b1, 1);
    push(3'd2, 1'b0, 2'b00, 1'b0, 1'b1, 3);
    step(OvrHold + 3);

    // Reset while an override is at hold count 2.
    ovr_valid = 1'b1;
    ovr_p     = 3'd3;
    push(3'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1);
    step(1);
    ovr_valid = 1'b0;
    push(3'd3, 1'b0, 2'b10, 1'b0, 1'b0, 2);
    step(2);
    reset = 1'b1;
    push(3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1);
    step(1);
    reset = 1'b0;
    push(3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 2);
    step(2);

    // Auto restarts from 0 with a load pulse.
    run = 1'b1;
    dir = 1'b0;
    push_auto(3'd0, 1'b0);
    push(3'd1, 1'b1, 2'b01, 1'b0, 1'b1, 1);
    step(Dwell + 1);

    total++;
    assert (exp_q.size() == 0) passed++;
    else $error("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
